seg7_scan_controller: RTL
=========================

// Module: seg7_scan_controller
// PURPOSE
//   Time-multiplexes NUM_DIGITS 4-bit BCD digits through one shared BCD-to-7-segment
//   code converter and drives a common-segment multi-digit display.
//   - Sequences one digit code per slot into the converter.
//   - Registers the returned segment pattern and enables one digit at a time.
//   - Inserts blanking dead-time between digits to prevent ghosting.
//   - Double-buffers the display value so updates land only on frame boundaries.
// PARAMETERS
//   NUM_DIGITS    4     digits scanned per frame (>=2)
//   REFRESH_DIV   1000  clk cycles each digit is lit (>=1)
//   BLANK_CYCLES  2     clk cycles all digits are off before each digit (>=1)
//   LZ_SUPPRESS   1     1 = blank leading zero digits (digit 0 is never blanked)
// PORTS
//   clk        in   1             rising-edge clock
//   rst_n      in   1             synchronous, active-low reset
//   en         in   1             scan enable
//   load       in   1             1-cycle strobe: capture digits_in into shadow buffer
//   digits_in  in   4*NUM_DIGITS  digit i = [4i+3:4i]; digit 0 = least significant
//   conv_code  out  4             code to shared converter inputs (w,x,y,z; w = MSB)
//   conv_seg   in   7             converter outputs a..g (a = bit 6); combinational, same cycle
//   seg_out    out  7             registered segment drive, a = bit 6, active-high
//   digit_en   out  NUM_DIGITS    one-hot digit enable, active-high; all zero when blanked
//   frame_done out  1             1-cycle pulse after the last digit's lit slot ends
//   busy       out  1             1 whenever state != IDLE
// BEHAVIOUR
//   Reset (rst_n=0 at an edge):
//     - state=IDLE; idx=0.
//     - active = shadow = 0; pending = 0.
//     - All outputs 0.
//     - rst_n low mid-scan aborts immediately; no partial frame completes.
//   States: IDLE, BLANK, SHOW. Counter cnt tracks cycles within the current state.
//   IDLE:
//     - digit_en = 0, seg_out = 0.
//     - en=1 -> BLANK with idx=0, cnt=0.
//   BLANK:
//     - digit_en = 0; conv_code = active[idx].
//     - After BLANK_CYCLES cycles -> SHOW. On that transition edge:
//       - seg_out <= conv_seg, or 0 if digit idx is suppressed;
//       - digit_en <= (1<<idx).
//   SHOW:
//     - Outputs held for exactly REFRESH_DIV cycles.
//     - conv_code is held at active[idx].
//     - At the end of the slot, on one edge:
//       - digit_en <= 0, seg_out <= 0;
//       - idx <= idx+1, wrapping to 0 after NUM_DIGITS-1;
//       - return to BLANK.
//   Frame wrap (idx NUM_DIGITS-1 -> 0):
//     - frame_done = 1 for one cycle.
//     - If pending: active <= shadow, pending <= 0.
//   Frame length = NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
//   Double buffering:
//     - load -> shadow <= digits_in, pending <= 1. Last load before a wrap wins.
//     - load on the wrap edge itself: digits_in goes straight to active; pending is cleared.
//     - load in IDLE: digits_in goes straight to active.
//   Leading-zero suppression (LZ_SUPPRESS=1):
//     - Digit i (i>0) is suppressed iff active[j]==0 for all j>=i.
//     - Suppressed digit: seg_out=0, but digit_en still pulses (timing unchanged).
//   Codes 10..15 are passed through unchanged; the converter's output is displayed as-is.
//   en deasserted in BLANK or SHOW:
//     - Next edge -> IDLE, outputs cleared, idx=0, frame_done not pulsed.
//     - shadow and pending are retained.
//   digit_en is never more than one-hot. Between any two digit_en pulses it is 0 for
//   exactly BLANK_CYCLES cycles.
// TESTING (bench: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1; behavioural BCD->7seg model,
//   0 -> 7'b1111110, 1 -> 7'b0110000, 8 -> 7'b1111111)
//   T1 reset: rst_n=0 for 2 edges with en=1 -> all outputs 0, busy=0; release -> first
//      digit_en=4'b0001 exactly 2 edges after rst_n rises.
//   T2 scan: load 16'h1208, en=1 -> digit_en sequence 0001,0010,0100,1000.
//      - Each one-hot value lasts 4 cycles, with 1 zero cycle between.
//      - seg_out = 8,0,2,1 patterns.
//      - frame_done pulses every 20 cycles.
//   T3 LZ: load 16'h0008, LZ_SUPPRESS=1 -> digits 1..3 give seg_out=0 with digit_en still
//      cycling. Repeat with LZ_SUPPRESS=0 -> digits 1..3 show 7'b1111110.
//   T4 double buffer: mid-frame load 16'h1111 then 16'h2222 -> current frame unchanged;
//      next frame shows all 2s. A load coincident with the frame_done edge is shown in the
//      frame that follows.
//   T5 en drop: deassert en during SHOW of digit 2 -> next edge digit_en=0, busy=0, no
//      frame_done. Reassert -> scan restarts at digit 0.
//   T6 invariants over 1000 random-load frames:
//      - $onehot0(digit_en) always holds.
//      - conv_code == active[idx] in every BLANK and SHOW cycle.
//      - Reset mid-SHOW clears everything in one edge.

Source files
------------

// File: rtl/seg7_scan_controller.sv
// Multiplexed 7-segment scan controller with one shared BCD converter.
// Double-buffered digits, blanking dead-time, leading-zero suppression.
module seg7_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter bit LZ_SUPPRESS  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              conv_code,
  input  logic [6:0]              conv_seg,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int DW   = 4 * NUM_DIGITS;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ?
                        REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_END  = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         active_q, active_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] den_q, den_d;
  logic                  fd_q, fd_d;

  logic [3:0]            cur_code;
  logic [NUM_DIGITS-1:0] hi_zero;
  logic                  suppress;
  logic                  last_digit;
  logic                  blank_done;
  logic                  show_done;
  logic                  wrap;

  assign cur_code   = active_q[{idx_q, 2'b00} +: 4];
  assign last_digit = (idx_q == LAST_IDX);
  assign blank_done = (cnt_q == BLANK_END);
  assign show_done  = (cnt_q == SHOW_END);

  // Frame wrap: last digit's lit slot ends while scanning stays enabled.
  assign wrap = (state_q == S_SHOW) && en && show_done && last_digit;

  // hi_zero[i] is set when digit i and every digit above it are zero.
  always_comb begin
    hi_zero = '0;
    hi_zero[NUM_DIGITS-1] = (active_q[DW-1 -: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      hi_zero[i] = hi_zero[i+1] && (active_q[4*i +: 4] == 4'd0);
    end
  end

  assign suppress = LZ_SUPPRESS && (idx_q != '0) && hi_zero[idx_q];

  // Converter is only fed while scanning; it reads the digit in flight.
  assign conv_code = (state_q != S_IDLE) ? cur_code : 4'd0;
  assign busy      = (state_q != S_IDLE);

  assign seg_out    = seg_q;
  assign digit_en   = den_q;
  assign frame_done = fd_q;

  // Scan sequencer: blank dead-time, then lit slot, per digit.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    den_d   = den_q;
    fd_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        seg_d = '0;
        den_d = '0;
        idx_d = '0;
        cnt_d = '0;
        if (en) begin
          state_d = S_BLANK;
        end
      end
      S_BLANK: begin
        if (!en) begin
          state_d = S_IDLE;
          seg_d   = '0;
          den_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (blank_done) begin
          state_d = S_SHOW;
          cnt_d   = '0;
          seg_d   = suppress ? 7'd0 : conv_seg;
          den_d   = NUM_DIGITS'(1) << idx_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (!en) begin
          state_d = S_IDLE;
          seg_d   = '0;
          den_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (show_done) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          seg_d   = '0;
          den_d   = '0;
          idx_d   = last_digit ? '0 : idx_q + 1'b1;
          fd_d    = last_digit;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        seg_d   = '0;
        den_d   = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Display buffers: new values reach the scan only at frame wrap or idle.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (state_q == S_IDLE) begin
      if (load) begin
        active_d  = digits_in;
        shadow_d  = digits_in;
        pending_d = 1'b0;
      end
    end else if (wrap) begin
      if (load) begin
        active_d  = digits_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      shadow_d  = digits_in;
      pending_d = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      seg_q     <= '0;
      den_q     <= '0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      den_q     <= den_d;
      fd_q      <= fd_d;
    end
  end

endmodule
